// File: rtl/mem_arbiter.sv
// Two-master round-robin arbiter for the picorv32 native memory bus. The grant is
// held for a whole transaction, and a watchdog completes hung accesses with ERR_DATA.
module mem_arbiter #(
    parameter int          TIMEOUT  = 255,
    parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
    input  logic        clk,
    input  logic        reset_n,

    input  logic        m0_valid,
    input  logic        m0_instr,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wstrb,
    output logic        m0_ready,
    output logic [31:0] m0_rdata,

    input  logic        m1_valid,
    input  logic        m1_instr,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wstrb,
    output logic        m1_ready,
    output logic [31:0] m1_rdata,

    output logic        s_valid,
    output logic        s_instr,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_wstrb,
    input  logic        s_ready,
    input  logic [31:0] s_rdata,

    output logic        bus_err,
    output logic [7:0]  err_count
);
    localparam int          NUM_M   = 2;
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

    typedef struct packed {
        logic        valid;
        logic        instr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } mem_req_t;

    typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

    state_t                 state, state_nxt;
    logic                   last;
    logic [15:0]            timer;
    mem_req_t [NUM_M-1:0]   req;
    mem_req_t               cur;
    logic                   gnt, sel, timeout_hit, done;
    logic [NUM_M-1:0]       m_ready;
    logic [NUM_M-1:0][31:0] m_rdata;

    assign req[0] = {m0_valid, m0_instr, m0_addr, m0_wdata, m0_wstrb};
    assign req[1] = {m1_valid, m1_instr, m1_addr, m1_wdata, m1_wstrb};

    // The granted master's request is forwarded verbatim; IDLE forwards all zeros.
    always_comb begin
        gnt         = (state != IDLE);
        sel         = (state == GNT1);
        cur         = gnt ? req[sel] : '0;
        timeout_hit = cur.valid & ~s_ready & (timer == TO_LAST);
        done        = cur.valid & (s_ready | timeout_hit);
    end

    assign s_valid = cur.valid;
    assign s_instr = cur.instr;
    assign s_addr  = cur.addr;
    assign s_wdata = cur.wdata;
    assign s_wstrb = cur.wstrb;
    assign bus_err = timeout_hit;

    for (genvar i = 0; i < NUM_M; i++) begin : g_rsp
        logic mine;
        assign mine       = gnt & (sel == 1'(i));
        assign m_ready[i] = mine & done;
        assign m_rdata[i] = mine ? (timeout_hit ? ERR_DATA : s_rdata) : '0;
    end

    assign m0_ready = m_ready[0];
    assign m1_ready = m_ready[1];
    assign m0_rdata = m_rdata[0];
    assign m1_rdata = m_rdata[1];

    // On a tie the master that was not granted last wins.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (req[0].valid && (!req[1].valid || last))
                    state_nxt = GNT0;
                else if (req[1].valid)
                    state_nxt = GNT1;
            end
            GNT0, GNT1: begin
                if (!cur.valid || done)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            last      <= 1'b1;
            timer     <= '0;
            err_count <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE) begin
                timer <= '0;
                if (state_nxt == GNT0)
                    last <= 1'b0;
                else if (state_nxt == GNT1)
                    last <= 1'b1;
            end else if (!s_ready) begin
                timer <= timer + 16'd1;
            end
            if (timeout_hit && err_count != 8'hFF)
                err_count <= err_count + 8'd1;
        end
    end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-master, one-slave arbiter for the picorv32 native memory interface.
- Shares the SoC slave bus between the CPU (m0) and a second requester (m1), e.g. the UART program loader or a DMA engine.
- Sits between the masters and the existing address decode / slave mux.
- Round-robin grant, holds the grant for the whole transaction, and has a slave-timeout watchdog that completes hung accesses with an error word.

Parameters:
TIMEOUT, 255, cycles a granted access may wait for s_ready before forced completion; legal range 1..65535.
ERR_DATA, 32'hDEAD_BEEF, rdata returned to the master on a timed-out access.

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
m0_valid  in  1  CPU request, held until m0_ready
m0_instr  in  1  CPU instruction fetch flag
m0_addr  in  32  CPU address
m0_wdata  in  32  CPU write data
m0_wstrb  in  4  CPU byte write enables (0 = read)
m0_ready  out  1  CPU transaction complete
m0_rdata  out  32  CPU read data
m1_valid, m1_instr, m1_addr, m1_wdata, m1_wstrb  in  1/1/32/32/4  second master request, same rules as m0
m1_ready  out  1  second master complete
m1_rdata  out  32  second master read data
s_valid  out  1  request to slave decode
s_instr  out  1  forwarded instr flag
s_addr  out  32  forwarded address
s_wdata  out  32  forwarded write data
s_wstrb  out  4  forwarded byte enables
s_ready  in  1  slave complete (OR of slave readies)
s_rdata  in  32  muxed slave read data
bus_err  out  1  one-cycle pulse on timeout completion
err_count  out  8  saturating count of timeouts

Behaviour:
- State machine: IDLE, GNT0, GNT1. State is registered; outputs are decoded from state.
- Reset values: state=IDLE, last=1 (so m0 wins first), timer=0, err_count=0, bus_err=0.
  - Combinational outputs during reset: s_valid=0, m0_ready=0, m1_ready=0, m*_rdata=0.
- IDLE arbitration:
  - Only m0_valid -> GNT0. Only m1_valid -> GNT1.
  - Both valid -> grant the master that is not `last`.
  - Neither valid -> stay in IDLE.
  - `last` updates to the granted index on entry to GNTx.
- Grant latency: request seen in IDLE at cycle N; s_valid rises at N+1.
- In GNTx:
  - s_valid = mx_valid.
  - s_instr, s_addr, s_wdata, s_wstrb = master x fields, combinational passthrough.
  - Non-granted master: ready=0, rdata=0.
  - mx_ready = s_ready | timeout_hit, same cycle (combinational).
  - mx_rdata = timeout_hit ? ERR_DATA : s_rdata.
  - In IDLE: s_valid=0 and all s_* fields = 0.
- Completion: the cycle mx_ready=1, next state is IDLE, so s_valid is low for at least one cycle between transactions. No back-to-back grants.
- Timer:
  - Cleared on entry to GNTx; increments each GNTx cycle in which s_ready=0.
  - timeout_hit = (timer == TIMEOUT-1) & ~s_ready.
  - On timeout_hit: bus_err=1 for that cycle, err_count += 1 (saturating at 255), return to IDLE.
  - If s_ready and the timeout fall in the same cycle, s_ready wins: normal data, no error.
- Abort: if mx_valid drops while in GNTx before ready, go to IDLE next cycle. No ready and no error are issued, and `last` is kept.
- Write semantics are untouched: wstrb passes through and rdata is ignored by the master.
- Reset mid-transaction: immediate return to IDLE, all outputs to reset values, and any in-flight slave access is dropped.
- Fairness: with both masters continuously requesting, grants strictly alternate m0, m1, m0, ...

Test Plan:
1. Reset, m0 read of addr 0x00000010 only, slave ready after 2 cycles with rdata 0x12345678 -> s_valid high 1 cycle after m0_valid; m0_ready pulse with m0_rdata 0x12345678; state back to IDLE; m1_ready stays 0.
2. m0 and m1 both assert at the same cycle after reset, slave ready in 1 cycle -> m0 served first, then m1. With both held continuously for 4 transactions, the grant order is 0,1,0,1.
3. m1 write to 0x80000000, wstrb=4'b0001, wdata=0x5 -> s_addr/s_wdata/s_wstrb equal m1 values while in GNT1; m0_ready=0 throughout.
4. TIMEOUT=8, granted access with s_ready held 0 -> mx_ready and bus_err pulse on the 8th grant cycle; mx_rdata=0xDEADBEEF; err_count=1. Repeat 300 times -> err_count saturates at 255.
5. s_ready asserted exactly on the timeout cycle -> normal rdata, bus_err=0, err_count unchanged.
6. Two abort cases:
   - m0 drops valid 2 cycles into GNT0 -> IDLE next cycle, no m0_ready.
   - reset_n pulsed low during a GNT1 wait -> s_valid falls immediately (asynchronously); all outputs return to reset values.
